// File: rtl/uart_rx_ctrl_if.sv
// Controller-side bundle of the UART receiver: serial line, shift-register
// strobe and parallel data, and the host status/acknowledge signals.
interface uart_rx_ctrl_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     serial_in;
  logic [NUM_DATA_BITS-1:0] rcv_data;
  logic                     data_read;
  logic                     shift_enable;
  logic [NUM_DATA_BITS-1:0] rx_data;
  logic                     data_ready;
  logic                     framing_error;
  logic                     overrun_error;
  logic                     busy;

  modport slave (
    input  serial_in, rcv_data, data_read,
    output shift_enable, rx_data, data_ready, framing_error, overrun_error, busy
  );

  modport master (
    output serial_in, rcv_data, data_read,
    input  shift_enable, rx_data, data_ready, framing_error, overrun_error, busy
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start-edge detection, bit timing, shift strobes,
// stop-bit check and holding register with ready/framing/overrun status.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  uart_rx_ctrl_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BITS_LAST = BW'(NUM_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    LOAD  = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_step_s;
  logic [BW-1:0]            bit_q, bit_d, bit_step_s;
  logic                     prev_in_q;
  logic                     shift_en_q, shift_en_d;
  logic [NUM_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                     ready_q, ready_d;
  logic                     fe_q, fe_d;
  logic                     ovr_q, ovr_d;
  logic                     busy_q, busy_d;
  logic                     start_edge_s;
  logic                     host_ack_s;

  // Next-state, counter and status logic.
  always_comb begin
    state_d    = state_q;
    cnt_step_s = cnt_q + CNT_ONE;
    bit_step_s = bit_q;
    shift_en_d = 1'b0;
    rx_data_d  = rx_data_q;
    ready_d    = ready_q;
    fe_d       = fe_q;
    ovr_d      = ovr_q;

    start_edge_s = prev_in_q & ~bus.serial_in;
    host_ack_s   = bus.data_read & ready_q & (state_q != LOAD);

    if (host_ack_s) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      ready_d = ready_q;
      ovr_d   = ovr_q;
    end

    case (state_q)
      IDLE: begin
        cnt_step_s = CNT_ZERO;
        if (start_edge_s) begin
          state_d = START;
          fe_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          state_d = bus.serial_in ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        // Registered strobe is launched one cycle early so it lands on the midpoint cycle.
        shift_en_d = (cnt_q == PRE_LAST);
        if (cnt_q == BIT_LAST) begin
          cnt_step_s = CNT_ZERO;
          if (bit_q == BITS_LAST) begin
            state_d = STOP;
          end else begin
            bit_step_s = bit_q + BIT_ONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (bus.serial_in) begin
            state_d = LOAD;
          end else begin
            fe_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      LOAD: begin
        rx_data_d = bus.rcv_data;
        ready_d   = 1'b1;
        if (ready_q && !bus.data_read) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cnt_d  = (state_d != state_q) ? CNT_ZERO : cnt_step_s;
    bit_d  = (state_d != state_q) ? BIT_ZERO : bit_step_s;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; rst_i overrides every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      bit_q      <= BIT_ZERO;
      prev_in_q  <= 1'b1;
      shift_en_q <= 1'b0;
      rx_data_q  <= {NUM_DATA_BITS{1'b0}};
      ready_q    <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      prev_in_q  <= bus.serial_in;
      shift_en_q <= shift_en_d;
      rx_data_q  <= rx_data_d;
      ready_q    <= ready_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.shift_enable  = shift_en_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = ready_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun_error = ovr_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural shift register and
// scoreboard queues for strobe timing and received bytes.
module tb_uart_rx_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  int   strobe_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] shreg;
  logic [7:0] exp_b;
  logic       dr96;
  int         t0;

  uart_rx_ctrl_if #(.NUM_DATA_BITS(8)) bus ();

  uart_rx_ctrl #(.CLKS_PER_BIT(10), .NUM_DATA_BITS(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External serial-to-parallel register, LSB-first.
  always @(posedge clk) if (bus.shift_enable) shreg <= {bus.serial_in, shreg[7:1]};
  assign bus.rcv_data = shreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest expected strobe cycle.
  always @(negedge clk) begin
    if (bus.shift_enable === 1'b1) begin
      if (strobe_q.size() == 0) begin
        chk("unexpected_strobe", cyc, 32'hFFFF_FFFF);
      end else begin
        chk("strobe_cycle", cyc, strobe_q.pop_front());
      end
    end
  end

  task automatic wait_to(input int c);
    repeat (c - cyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic rd_load,
                            output int ts, output logic dr_at96);
    @(posedge clk); #1;
    bus.serial_in = 1'b0;
    ts = cyc;
    chk("busy_cycle0", bus.busy, 32'd0);
    for (int k = 1; k <= 8; k++) strobe_q.push_back(ts + 5 + 10 * k);
    if (stop_b) byte_q.push_back(b);
    wait_to(ts + 1);
    chk("busy_cycle1", bus.busy, 32'd1);
    for (int i = 0; i < 8; i++) begin
      wait_to(ts + 10 + 10 * i);
      bus.serial_in = b[i];
    end
    wait_to(ts + 90);
    bus.serial_in = stop_b;
    wait_to(ts + 96);
    chk("busy_load", bus.busy, {31'd0, stop_b});
    dr_at96 = bus.data_ready;
    bus.data_read = rd_load;
    wait_to(ts + 97);
    bus.data_read = 1'b0;
    chk("strobes_left", strobe_q.size(), 32'd0);
  endtask

  task automatic end_frame(input int ts);
    wait_to(ts + 100);
    bus.serial_in = 1'b1;
  endtask

  task automatic pulse_read();
    @(posedge clk); #1;
    bus.data_read = 1'b1;
    @(posedge clk); #1;
    bus.data_read = 1'b0;
  endtask

  initial begin
    cyc = 0; total = 0; bad = 0;
    shreg = 8'h00;
    rst = 1'b1;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_shift_enable", bus.shift_enable, 32'd0);
    chk("rst_rx_data", bus.rx_data, 32'd0);
    chk("rst_data_ready", bus.data_ready, 32'd0);
    chk("rst_framing", bus.framing_error, 32'd0);
    chk("rst_overrun", bus.overrun_error, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    rst = 1'b0;
    wait_to(cyc + 3);

    // Frame 0xA5: strobes at 15..85, ready visible from cycle 97.
    send_frame(8'hA5, 1'b1, 1'b0, t0, dr96);
    chk("a5_ready_at_96", dr96, 32'd0);
    exp_b = byte_q.pop_front();
    chk("a5_rx_data", bus.rx_data, {24'd0, exp_b});
    chk("a5_ready", bus.data_ready, 32'd1);
    chk("a5_framing", bus.framing_error, 32'd0);
    chk("a5_overrun", bus.overrun_error, 32'd0);
    wait_to(t0 + 98);
    chk("a5_busy_after", bus.busy, 32'd0);
    end_frame(t0);
    wait_to(cyc + 5);

    // Three-cycle low glitch aborts at the cycle-5 sample.
    @(posedge clk); #1;
    bus.serial_in = 1'b0;
    t0 = cyc;
    wait_to(t0 + 3);
    bus.serial_in = 1'b1;
    wait_to(t0 + 5);
    chk("glitch_busy_start", bus.busy, 32'd1);
    wait_to(t0 + 6);
    chk("glitch_busy_drop", bus.busy, 32'd0);
    chk("glitch_ready", bus.data_ready, 32'd1);
    chk("glitch_rx_data", bus.rx_data, 32'h0000_00A5);
    chk("glitch_framing", bus.framing_error, 32'd0);
    chk("glitch_overrun", bus.overrun_error, 32'd0);
    wait_to(t0 + 12);

    pulse_read();
    chk("read_clears_ready", bus.data_ready, 32'd0);
    pulse_read();
    chk("read_when_empty", bus.data_ready, 32'd0);

    // 0x3C with low stop bit is discarded and flagged.
    send_frame(8'h3C, 1'b0, 1'b0, t0, dr96);
    chk("fe_set", bus.framing_error, 32'd1);
    chk("fe_ready", bus.data_ready, 32'd0);
    chk("fe_rx_data", bus.rx_data, 32'h0000_00A5);
    end_frame(t0);
    wait_to(cyc + 4);
    chk("fe_line_low_no_start", bus.busy, 32'd0);

    send_frame(8'h81, 1'b1, 1'b0, t0, dr96);
    exp_b = byte_q.pop_front();
    chk("81_rx_data", bus.rx_data, {24'd0, exp_b});
    chk("81_fe_cleared", bus.framing_error, 32'd0);
    chk("81_ready", bus.data_ready, 32'd1);
    end_frame(t0);
    pulse_read();

    // Overrun: two frames back to back with no read.
    send_frame(8'h11, 1'b1, 1'b0, t0, dr96);
    exp_b = byte_q.pop_front();
    chk("11_rx_data", bus.rx_data, {24'd0, exp_b});
    chk("11_overrun", bus.overrun_error, 32'd0);
    end_frame(t0);
    send_frame(8'h22, 1'b1, 1'b0, t0, dr96);
    exp_b = byte_q.pop_front();
    chk("22_rx_data", bus.rx_data, {24'd0, exp_b});
    chk("22_overrun", bus.overrun_error, 32'd1);
    chk("22_ready", bus.data_ready, 32'd1);
    end_frame(t0);
    pulse_read();
    chk("ovr_read_ready", bus.data_ready, 32'd0);
    chk("ovr_read_overrun", bus.overrun_error, 32'd0);

    // Read coincident with LOAD of the second frame.
    send_frame(8'h33, 1'b1, 1'b0, t0, dr96);
    exp_b = byte_q.pop_front();
    chk("33_rx_data", bus.rx_data, {24'd0, exp_b});
    end_frame(t0);
    send_frame(8'h44, 1'b1, 1'b1, t0, dr96);
    exp_b = byte_q.pop_front();
    chk("44_rx_data", bus.rx_data, {24'd0, exp_b});
    chk("44_ready", bus.data_ready, 32'd1);
    chk("44_overrun", bus.overrun_error, 32'd0);
    end_frame(t0);
    wait_to(cyc + 3);

    // Reset at cycle 40 of a frame.
    @(posedge clk); #1;
    bus.serial_in = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 3; k++) strobe_q.push_back(t0 + 5 + 10 * k);
    for (int i = 0; i < 4; i++) begin
      wait_to(t0 + 10 + 10 * i);
      bus.serial_in = i[0] ? 1'b0 : 1'b1;
    end
    wait_to(t0 + 40);
    rst = 1'b1;
    wait_to(t0 + 41);
    rst = 1'b0;
    bus.serial_in = 1'b1;
    chk("mid_rst_shift_enable", bus.shift_enable, 32'd0);
    chk("mid_rst_rx_data", bus.rx_data, 32'd0);
    chk("mid_rst_ready", bus.data_ready, 32'd0);
    chk("mid_rst_framing", bus.framing_error, 32'd0);
    chk("mid_rst_overrun", bus.overrun_error, 32'd0);
    chk("mid_rst_busy", bus.busy, 32'd0);
    chk("mid_rst_strobes", strobe_q.size(), 32'd0);
    wait_to(cyc + 20);
    chk("mid_rst_stays_idle", bus.busy, 32'd0);

    send_frame(8'hFF, 1'b1, 1'b0, t0, dr96);
    exp_b = byte_q.pop_front();
    chk("ff_rx_data", bus.rx_data, {24'd0, exp_b});
    chk("ff_ready", bus.data_ready, 32'd1);
    chk("ff_framing", bus.framing_error, 32'd0);
    chk("ff_overrun", bus.overrun_error, 32'd0);
    end_frame(t0);
    wait_to(cyc + 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
